// File: rtl/eth_hdr_strip.sv
`default_nettype none
// ============================================================================
//  Module      : eth_hdr_strip
//  Description : Ethernet header stripper. Captures destination MAC, source
//                MAC and EtherType from a byte-wide AXI-Stream frame and
//                forwards only the payload through a single output register.
//                Frames that end inside the header are flagged as runts.
//                Frames whose EtherType does not match ACCEPT_ETYPE are
//                discarded.
//                Optional build macro ETH_HDR_STATS_EN enables saturating
//                drop/runt event counters. When it is undefined, both stat
//                ports read as zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module eth_hdr_strip #(
    parameter logic [15:0] ACCEPT_ETYPE = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_tvalid,
    output logic        in_tready,
    input  logic        in_tlast,
    input  logic [7:0]  in_tdata,
    output logic        out_tvalid,
    input  logic        out_tready,
    output logic        out_tlast,
    output logic [7:0]  out_tdata,
    output logic        hdr_valid,
    output logic [47:0] hdr_dst_mac,
    output logic [47:0] hdr_src_mac,
    output logic [15:0] hdr_ethertype,
    output logic        err_runt,
    output logic        drop_etype,
    output logic [15:0] stat_drop_cnt,
    output logic [15:0] stat_runt_cnt
);

    typedef enum logic [1:0] {
        ST_HDR     = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_DROP    = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [47:0] dst_sh_q, dst_sh_d;
    logic [47:0] src_sh_q, src_sh_d;
    // Only the EtherType high byte needs a shadow; the low byte is used
    // directly on the cycle it is accepted.
    logic [7:0]  et_hi_q, et_hi_d;
    logic        out_valid_q, out_valid_d;
    logic        out_last_q, out_last_d;
    logic [7:0]  out_data_q, out_data_d;
    logic        hdr_valid_q, hdr_valid_d;
    logic [47:0] hdr_dst_q, hdr_dst_d;
    logic [47:0] hdr_src_q, hdr_src_d;
    logic [15:0] hdr_etype_q, hdr_etype_d;
    logic        err_runt_q, err_runt_d;
    logic        drop_etype_q, drop_etype_d;

    logic        w_in_xfer;
    logic [15:0] w_etype;
    logic        w_etype_ok;

    // Header and drop states always accept; the payload state accepts only
    // when the output register is empty or being drained this cycle.
    assign in_tready  = rst_n && ((state_q != ST_PAYLOAD) || !out_valid_q || out_tready);
    assign w_in_xfer  = in_tvalid && in_tready;
    assign w_etype    = {et_hi_q, in_tdata};
    assign w_etype_ok = (ACCEPT_ETYPE == 16'h0000) || (w_etype == ACCEPT_ETYPE);

    // Next-state, header capture and output-register load.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        dst_sh_d     = dst_sh_q;
        src_sh_d     = src_sh_q;
        et_hi_d      = et_hi_q;
        out_valid_d  = out_valid_q;
        out_last_d   = out_last_q;
        out_data_d   = out_data_q;
        hdr_valid_d  = 1'b0;
        hdr_dst_d    = hdr_dst_q;
        hdr_src_d    = hdr_src_q;
        hdr_etype_d  = hdr_etype_q;
        err_runt_d   = 1'b0;
        drop_etype_d = 1'b0;

        if (out_valid_q && out_tready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            ST_HDR: begin
                if (w_in_xfer) begin
                    if (in_tlast) begin
                        // Frame ended before the payload started.
                        err_runt_d = 1'b1;
                        cnt_d      = 4'd0;
                    end else begin
                        // Shift-in keeps the first byte in the top bits.
                        if (cnt_q < 4'd6) begin
                            dst_sh_d = {dst_sh_q[39:0], in_tdata};
                        end else if (cnt_q < 4'd12) begin
                            src_sh_d = {src_sh_q[39:0], in_tdata};
                        end else if (cnt_q == 4'd12) begin
                            et_hi_d = in_tdata;
                        end

                        if (cnt_q == 4'd13) begin
                            cnt_d = 4'd0;
                            if (w_etype_ok) begin
                                hdr_dst_d   = dst_sh_q;
                                hdr_src_d   = src_sh_q;
                                hdr_etype_d = w_etype;
                                hdr_valid_d = 1'b1;
                                state_d     = ST_PAYLOAD;
                            end else begin
                                drop_etype_d = 1'b1;
                                state_d      = ST_DROP;
                            end
                        end else begin
                            cnt_d = cnt_q + 4'd1;
                        end
                    end
                end
            end
            ST_PAYLOAD: begin
                if (w_in_xfer) begin
                    out_valid_d = 1'b1;
                    out_data_d  = in_tdata;
                    out_last_d  = in_tlast;
                    if (in_tlast) begin
                        state_d = ST_HDR;
                        cnt_d   = 4'd0;
                    end
                end
            end
            ST_DROP: begin
                if (w_in_xfer && in_tlast) begin
                    state_d = ST_HDR;
                    cnt_d   = 4'd0;
                end
            end
            default: begin
                state_d = ST_HDR;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // State and datapath registers, cleared immediately by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_HDR;
            cnt_q        <= 4'd0;
            dst_sh_q     <= 48'd0;
            src_sh_q     <= 48'd0;
            et_hi_q      <= 8'd0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            out_data_q   <= 8'd0;
            hdr_valid_q  <= 1'b0;
            hdr_dst_q    <= 48'd0;
            hdr_src_q    <= 48'd0;
            hdr_etype_q  <= 16'd0;
            err_runt_q   <= 1'b0;
            drop_etype_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            dst_sh_q     <= dst_sh_d;
            src_sh_q     <= src_sh_d;
            et_hi_q      <= et_hi_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            out_data_q   <= out_data_d;
            hdr_valid_q  <= hdr_valid_d;
            hdr_dst_q    <= hdr_dst_d;
            hdr_src_q    <= hdr_src_d;
            hdr_etype_q  <= hdr_etype_d;
            err_runt_q   <= err_runt_d;
            drop_etype_q <= drop_etype_d;
        end
    end

    assign out_tvalid    = out_valid_q;
    assign out_tlast     = out_last_q;
    assign out_tdata     = out_data_q;
    assign hdr_valid     = hdr_valid_q;
    assign hdr_dst_mac   = hdr_dst_q;
    assign hdr_src_mac   = hdr_src_q;
    assign hdr_ethertype = hdr_etype_q;
    assign err_runt      = err_runt_q;
    assign drop_etype    = drop_etype_q;

`ifdef ETH_HDR_STATS_EN
    logic [15:0] stat_drop_q, stat_drop_d;
    logic [15:0] stat_runt_q, stat_runt_d;

    // Saturating event counters, updated together with the event pulses.
    always_comb begin
        stat_drop_d = stat_drop_q;
        stat_runt_d = stat_runt_q;
        if (drop_etype_d && (stat_drop_q != 16'hFFFF)) begin
            stat_drop_d = stat_drop_q + 16'd1;
        end
        if (err_runt_d && (stat_runt_q != 16'hFFFF)) begin
            stat_runt_d = stat_runt_q + 16'd1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_drop_q <= 16'd0;
            stat_runt_q <= 16'd0;
        end else begin
            stat_drop_q <= stat_drop_d;
            stat_runt_q <= stat_runt_d;
        end
    end

    assign stat_drop_cnt = stat_drop_q;
    assign stat_runt_cnt = stat_runt_q;
`else
    assign stat_drop_cnt = 16'd0;
    assign stat_runt_cnt = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_eth_hdr_strip.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_eth_hdr_strip
//  Description : Directed self-checking bench for eth_hdr_strip. Instance
//                "a" accepts all EtherTypes. Instance "b" accepts only 0806.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_eth_hdr_strip;

`ifdef ETH_HDR_STATS_EN
    localparam int STATS = 1;
`else
    localparam int STATS = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  in_tdata = 8'd0;
    logic        in_tlast = 1'b0;
    logic        in_tvalid_a = 1'b0;
    logic        in_tvalid_b = 1'b0;
    logic        out_tready = 1'b1;

    logic        a_in_tready, a_out_tvalid, a_out_tlast, a_hdr_valid, a_err_runt, a_drop_etype;
    logic [7:0]  a_out_tdata;
    logic [47:0] a_hdr_dst, a_hdr_src;
    logic [15:0] a_hdr_etype, a_stat_drop, a_stat_runt;
    logic        b_in_tready, b_out_tvalid, b_out_tlast, b_hdr_valid, b_err_runt, b_drop_etype;
    logic [7:0]  b_out_tdata;
    logic [47:0] b_hdr_dst, b_hdr_src;
    logic [15:0] b_hdr_etype, b_stat_drop, b_stat_runt;

    always #5 clk = ~clk;

    eth_hdr_strip #(.ACCEPT_ETYPE(16'h0000)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_tvalid(in_tvalid_a), .in_tready(a_in_tready), .in_tlast(in_tlast), .in_tdata(in_tdata),
        .out_tvalid(a_out_tvalid), .out_tready(out_tready), .out_tlast(a_out_tlast), .out_tdata(a_out_tdata),
        .hdr_valid(a_hdr_valid), .hdr_dst_mac(a_hdr_dst), .hdr_src_mac(a_hdr_src), .hdr_ethertype(a_hdr_etype),
        .err_runt(a_err_runt), .drop_etype(a_drop_etype),
        .stat_drop_cnt(a_stat_drop), .stat_runt_cnt(a_stat_runt)
    );

    eth_hdr_strip #(.ACCEPT_ETYPE(16'h0806)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_tvalid(in_tvalid_b), .in_tready(b_in_tready), .in_tlast(in_tlast), .in_tdata(in_tdata),
        .out_tvalid(b_out_tvalid), .out_tready(1'b1), .out_tlast(b_out_tlast), .out_tdata(b_out_tdata),
        .hdr_valid(b_hdr_valid), .hdr_dst_mac(b_hdr_dst), .hdr_src_mac(b_hdr_src), .hdr_ethertype(b_hdr_etype),
        .err_runt(b_err_runt), .drop_etype(b_drop_etype),
        .stat_drop_cnt(b_stat_drop), .stat_runt_cnt(b_stat_runt)
    );

    int checks = 0;
    int errors = 0;

    // Reference frame: dst DEADBEEF1234, src 000A35123456, etype 0800, "Hello".
    logic [7:0] good [0:18];
    logic [8:0] exp_hello [0:4];

    // out_tready pattern: 0 = always ready, 1 = toggle each cycle, 2 = held low.
    int rmode = 0;
    always @(posedge clk) begin
        #2;
        case (rmode)
            0:       out_tready = 1'b1;
            1:       out_tready = ~out_tready;
            default: out_tready = 1'b0;
        endcase
    end

    // Observer on the falling edge: handshake signals are settled here.
    logic [8:0] got [0:255];
    int   got_n = 0, hv_cnt = 0, runt_cnt = 0, b_drop_cnt = 0, b_out_cnt = 0, b_hv_cnt = 0, stall_viol = 0;
    logic       prev_stall = 1'b0;
    logic [8:0] prev_word = 9'd0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && (!a_out_tvalid || ({a_out_tlast, a_out_tdata} !== prev_word)))
                stall_viol++;
            if (a_out_tvalid && out_tready) begin
                if (got_n < 256) got[got_n] = {a_out_tlast, a_out_tdata};
                got_n++;
            end
            prev_stall = a_out_tvalid && !out_tready;
            prev_word  = {a_out_tlast, a_out_tdata};
            if (a_hdr_valid)  hv_cnt++;
            if (a_err_runt)   runt_cnt++;
            if (b_drop_etype) b_drop_cnt++;
            if (b_out_tvalid) b_out_cnt++;
            if (b_hdr_valid)  b_hv_cnt++;
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present one byte to instance a (tgt=0) or b (tgt=1) until it is accepted.
    task automatic send_byte(input logic [7:0] d, input logic last, input bit tgt);
        int t;
        in_tdata = d;
        in_tlast = last;
        if (tgt) in_tvalid_b = 1'b1;
        else     in_tvalid_a = 1'b1;
        t = 0;
        forever begin
            @(negedge clk);
            if ((tgt ? b_in_tready : a_in_tready) === 1'b1) break;
            t++;
            if (t > 100) begin
                checks++; errors++;
                $display("FAIL send_timeout: byte %h not accepted, got ready=0 required 1", d);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_tvalid_a = 1'b0;
        in_tvalid_b = 1'b0;
        in_tlast    = 1'b0;
    endtask

    task automatic send_good(input int first, input int n, input bit with_last, input bit tgt);
        for (int i = first; i < first + n; i++)
            send_byte(good[i], with_last && (i == first + n - 1), tgt);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cycles(3);
        checks += 9;
        if (a_in_tready !== 1'b0)  begin errors++; $display("FAIL rst_in_tready: got %b required 0", a_in_tready); end
        if (b_in_tready !== 1'b0)  begin errors++; $display("FAIL rst_in_tready_b: got %b required 0", b_in_tready); end
        if (a_out_tvalid !== 1'b0) begin errors++; $display("FAIL rst_out_tvalid: got %b required 0", a_out_tvalid); end
        if ({a_out_tlast, a_out_tdata} !== 9'd0) begin errors++; $display("FAIL rst_out_data: got %h required 000", {a_out_tlast, a_out_tdata}); end
        if (a_hdr_dst !== 48'd0 || a_hdr_src !== 48'd0) begin errors++; $display("FAIL rst_hdr_mac: got %h/%h required 0", a_hdr_dst, a_hdr_src); end
        if (a_hdr_etype !== 16'd0) begin errors++; $display("FAIL rst_hdr_etype: got %h required 0000", a_hdr_etype); end
        if ({a_hdr_valid, a_err_runt, a_drop_etype} !== 3'b000) begin errors++; $display("FAIL rst_pulses: got %b required 000", {a_hdr_valid, a_err_runt, a_drop_etype}); end
        if (a_stat_drop !== 16'd0 || a_stat_runt !== 16'd0) begin errors++; $display("FAIL rst_stats: got %h/%h required 0", a_stat_drop, a_stat_runt); end
        rst_n = 1'b1;
        #1;
        if (a_in_tready !== 1'b1)  begin errors++; $display("FAIL rel_in_tready: got %b required 1", a_in_tready); end
    endtask

    task automatic test_basic();
        int s, h;
        s = got_n; h = hv_cnt;
        rmode = 0;
        send_good(0, 19, 1'b1, 1'b0);
        cycles(5);
        checks++;
        if (got_n - s !== 5) begin errors++; $display("FAIL basic_count: got %0d bytes required 5", got_n - s); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (got[s + i] !== exp_hello[i]) begin errors++; $display("FAIL basic_byte%0d: got %h required %h", i, got[s + i], exp_hello[i]); end
        end
        checks += 2;
        if (hv_cnt - h !== 1) begin errors++; $display("FAIL basic_hdr_valid: got %0d pulses required 1", hv_cnt - h); end
        if (a_hdr_dst !== 48'hDEADBEEF1234 || a_hdr_src !== 48'h000A35123456 || a_hdr_etype !== 16'h0800) begin
            errors++; $display("FAIL basic_hdr: got %h %h %h required DEADBEEF1234 000A35123456 0800", a_hdr_dst, a_hdr_src, a_hdr_etype);
        end
    endtask

    task automatic test_backpressure();
        int s, v;
        s = got_n; v = stall_viol;
        rmode = 1;
        send_good(0, 19, 1'b1, 1'b0);
        cycles(10);
        rmode = 0;
        cycles(2);
        checks += 2;
        if (got_n - s !== 5) begin errors++; $display("FAIL bp_count: got %0d bytes required 5", got_n - s); end
        if (stall_viol - v !== 0) begin errors++; $display("FAIL bp_stable: got %0d unstable stalls required 0", stall_viol - v); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (got[s + i] !== exp_hello[i]) begin errors++; $display("FAIL bp_byte%0d: got %h required %h", i, got[s + i], exp_hello[i]); end
        end
    endtask

    task automatic test_etype_filter();
        int d, o, h;
        d = b_drop_cnt; o = b_out_cnt; h = b_hv_cnt;
        send_good(0, 19, 1'b1, 1'b1);
        cycles(4);
        checks += 5;
        if (b_out_cnt - o !== 0)  begin errors++; $display("FAIL etype_out: got %0d valid cycles required 0", b_out_cnt - o); end
        if (b_drop_cnt - d !== 1) begin errors++; $display("FAIL etype_drop: got %0d pulses required 1", b_drop_cnt - d); end
        if (b_hv_cnt - h !== 0)   begin errors++; $display("FAIL etype_hdr_valid: got %0d pulses required 0", b_hv_cnt - h); end
        if (b_hdr_dst !== 48'd0)  begin errors++; $display("FAIL etype_hdr_kept: got %h required 0", b_hdr_dst); end
        if (b_stat_drop !== 16'(STATS)) begin errors++; $display("FAIL etype_stat: got %0d required %0d", b_stat_drop, STATS); end
    endtask

    task automatic test_runt();
        int s, r, h;
        s = got_n; r = runt_cnt; h = hv_cnt;
        send_good(0, 10, 1'b1, 1'b0);
        send_good(0, 19, 1'b1, 1'b0);
        cycles(5);
        checks += 3;
        if (runt_cnt - r !== 1) begin errors++; $display("FAIL runt_pulse: got %0d pulses required 1", runt_cnt - r); end
        if (hv_cnt - h !== 1)   begin errors++; $display("FAIL runt_hdr_valid: got %0d pulses required 1", hv_cnt - h); end
        if (got_n - s !== 5)    begin errors++; $display("FAIL runt_count: got %0d bytes required 5", got_n - s); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (got[s + i] !== exp_hello[i]) begin errors++; $display("FAIL runt_byte%0d: got %h required %h", i, got[s + i], exp_hello[i]); end
        end
    endtask

    task automatic test_exact14();
        int s, r, h;
        s = got_n; r = runt_cnt; h = hv_cnt;
        send_good(0, 14, 1'b1, 1'b0);
        cycles(4);
        checks += 4;
        if (runt_cnt - r !== 1) begin errors++; $display("FAIL x14_runt: got %0d pulses required 1", runt_cnt - r); end
        if (hv_cnt - h !== 0)   begin errors++; $display("FAIL x14_hdr_valid: got %0d pulses required 0", hv_cnt - h); end
        if (got_n - s !== 0)    begin errors++; $display("FAIL x14_out: got %0d bytes required 0", got_n - s); end
        if (a_stat_runt !== 16'(2 * STATS)) begin errors++; $display("FAIL x14_stat_runt: got %0d required %0d", a_stat_runt, 2 * STATS); end
    endtask

    // One-byte frame held at the output while the next header streams in.
    task automatic test_back_to_back();
        int s, h, v;
        s = got_n; h = hv_cnt; v = stall_viol;
        rmode = 2;
        cycles(1);
        for (int i = 0; i < 12; i++) send_byte(good[i] ^ 8'hFF, 1'b0, 1'b0);
        send_byte(8'h08, 1'b0, 1'b0);
        send_byte(8'h00, 1'b0, 1'b0);
        send_byte(8'h58, 1'b1, 1'b0);
        send_good(0, 14, 1'b0, 1'b0);
        cycles(1);
        checks += 4;
        if ({a_out_tvalid, a_out_tlast, a_out_tdata} !== 10'h358) begin errors++; $display("FAIL b2b_held: got %h required 358", {a_out_tvalid, a_out_tlast, a_out_tdata}); end
        if (got_n - s !== 0) begin errors++; $display("FAIL b2b_no_early: got %0d bytes required 0", got_n - s); end
        if (hv_cnt - h !== 2) begin errors++; $display("FAIL b2b_hdr_valid: got %0d pulses required 2", hv_cnt - h); end
        if (a_hdr_dst !== 48'hDEADBEEF1234) begin errors++; $display("FAIL b2b_hdr_dst: got %h required DEADBEEF1234", a_hdr_dst); end
        rmode = 0;
        send_good(14, 5, 1'b1, 1'b0);
        cycles(5);
        checks += 3;
        if (got_n - s !== 6) begin errors++; $display("FAIL b2b_count: got %0d bytes required 6", got_n - s); end
        if (got[s] !== 9'h158) begin errors++; $display("FAIL b2b_first: got %h required 158", got[s]); end
        if (stall_viol - v !== 0) begin errors++; $display("FAIL b2b_stable: got %0d unstable stalls required 0", stall_viol - v); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (got[s + 1 + i] !== exp_hello[i]) begin errors++; $display("FAIL b2b_byte%0d: got %h required %h", i, got[s + 1 + i], exp_hello[i]); end
        end
    endtask

    task automatic test_mid_reset();
        int s, h;
        rmode = 0;
        send_good(0, 16, 1'b0, 1'b0);
        cycles(1);
        rst_n = 1'b0;
        #1;
        checks += 3;
        if (a_out_tvalid !== 1'b0) begin errors++; $display("FAIL mrst_out_tvalid: got %b required 0", a_out_tvalid); end
        if (a_in_tready !== 1'b0)  begin errors++; $display("FAIL mrst_in_tready: got %b required 0", a_in_tready); end
        if (a_hdr_dst !== 48'd0)   begin errors++; $display("FAIL mrst_hdr: got %h required 0", a_hdr_dst); end
        cycles(2);
        rst_n = 1'b1;
        cycles(1);
        s = got_n; h = hv_cnt;
        send_good(0, 19, 1'b1, 1'b0);
        cycles(5);
        checks += 3;
        if (got_n - s !== 5) begin errors++; $display("FAIL mrst_count: got %0d bytes required 5", got_n - s); end
        if (hv_cnt - h !== 1) begin errors++; $display("FAIL mrst_hdr_valid: got %0d pulses required 1", hv_cnt - h); end
        if (a_hdr_src !== 48'h000A35123456 || a_hdr_etype !== 16'h0800) begin errors++; $display("FAIL mrst_hdr_fields: got %h %h required 000A35123456 0800", a_hdr_src, a_hdr_etype); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (got[s + i] !== exp_hello[i]) begin errors++; $display("FAIL mrst_byte%0d: got %h required %h", i, got[s + i], exp_hello[i]); end
        end
    endtask

    initial begin
        good[0]  = 8'hDE; good[1]  = 8'hAD; good[2]  = 8'hBE; good[3]  = 8'hEF;
        good[4]  = 8'h12; good[5]  = 8'h34; good[6]  = 8'h00; good[7]  = 8'h0A;
        good[8]  = 8'h35; good[9]  = 8'h12; good[10] = 8'h34; good[11] = 8'h56;
        good[12] = 8'h08; good[13] = 8'h00; good[14] = 8'h48; good[15] = 8'h65;
        good[16] = 8'h6C; good[17] = 8'h6C; good[18] = 8'h6F;
        exp_hello[0] = 9'h048; exp_hello[1] = 9'h065; exp_hello[2] = 9'h06C;
        exp_hello[3] = 9'h06C; exp_hello[4] = 9'h16F;

        test_reset();
        test_basic();
        test_backpressure();
        test_etype_filter();
        test_runt();
        test_exact14();
        test_back_to_back();
        test_mid_reset();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
